// File: rtl/awmc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_pkg : shared stage encodings and motor-state enum              |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package awmc_pkg;

  typedef enum logic [2:0] {
    ST_FILL   = 3'b000,
    ST_WASH   = 3'b001,
    ST_DRAIN  = 3'b010,
    ST_REFILL = 3'b011,
    ST_RINSE  = 3'b100,
    ST_SPIN   = 3'b101,
    ST_RSVD   = 3'b110,
    ST_IDLE   = 3'b111
  } stage_e;

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_FWD     = 3'd1,
    M_DWELL_F = 3'd2,
    M_REV     = 3'd3,
    M_DWELL_R = 3'd4,
    M_SPIN    = 3'd5
  } motor_state_e;

  // The unused code folds onto IDLE so the rest of the design sees one idle value.
  function automatic stage_e decode_stage(input logic [2:0] raw);
    return (raw == 3'b110) ? ST_IDLE : stage_e'(raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/awmc_beeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_beeper : BEEP_COUNT on/off beeps per rising edge of trigger    |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module awmc_beeper #(
  parameter int unsigned BEEP_ON    = 2,
  parameter int unsigned BEEP_COUNT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  output logic buzzer
);

  localparam int PW = $clog2(BEEP_ON + 1);
  localparam int CW = $clog2(BEEP_COUNT + 1);
  localparam logic [PW-1:0] c_ph_last   = PW'(BEEP_ON - 1);
  localparam logic [CW-1:0] c_beep_last = CW'(BEEP_COUNT - 1);

  logic          r_trig_d;
  logic          r_active;
  logic          r_on;
  logic [PW-1:0] r_ph;
  logic [CW-1:0] r_beeps;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_d <= 1'b0;
      r_active <= 1'b0;
      r_on     <= 1'b0;
      r_ph     <= '0;
      r_beeps  <= '0;
    end else begin
      r_trig_d <= trigger;
      if (!r_active) begin
        if (trigger && !r_trig_d) begin
          r_active <= 1'b1;
          r_on     <= 1'b1;
          r_ph     <= '0;
          r_beeps  <= '0;
        end
      end else if (r_ph != c_ph_last) begin
        r_ph <= r_ph + 1'b1;
      end else begin
        r_ph <= '0;
        if (r_on) begin
          r_on <= 1'b0;
        end else if (r_beeps == c_beep_last) begin
          r_active <= 1'b0;
        end else begin
          r_beeps <= r_beeps + 1'b1;
          r_on    <= 1'b1;
        end
      end
    end
  end

  assign buzzer = r_on;

endmodule
`default_nettype wire

// File: rtl/awmc_actuator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | awmc_actuator_ctrl : washer valve/pump/motor/lock/beeper sequencer  |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
module awmc_actuator_ctrl
  import awmc_pkg::*;
#(
  parameter int unsigned REV_CYCLES   = 8,
  parameter int unsigned DWELL_CYCLES = 2,
  parameter int unsigned FILL_TIMEOUT = 16,
  parameter int unsigned LOCK_HOLD    = 4,
  parameter int unsigned BEEP_ON      = 2,
  parameter int unsigned BEEP_COUNT   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] stage,
  input  logic       done,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       water_empty,
  output logic       inlet_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);

  localparam int PH_MAX = (REV_CYCLES > DWELL_CYCLES) ? REV_CYCLES : DWELL_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FC_W   = $clog2(FILL_TIMEOUT + 1);
  localparam int HW     = $clog2(LOCK_HOLD + 1);
  localparam logic [PH_W-1:0] c_rev_last   = PH_W'(REV_CYCLES - 1);
  localparam logic [PH_W-1:0] c_dwell_last = PH_W'(DWELL_CYCLES - 1);
  localparam logic [FC_W-1:0] c_fill_to    = FC_W'(FILL_TIMEOUT);
  localparam logic [HW-1:0]   c_hold       = HW'(LOCK_HOLD);

  stage_e          w_stage, r_prev_stage;
  motor_state_e    r_state, w_state_nxt;
  logic [PH_W-1:0] r_ph_cnt, w_ph_nxt;
  logic [FC_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic            w_stage_chg, w_is_fill, w_agitate, w_idle;
  logic            w_fill_to, w_door_flt, w_fault_nxt;
  logic            w_en_nxt, w_dir_nxt;
  logic            r_inlet, r_drain, r_motor_en, r_motor_dir, r_fast, r_lock, r_fault;

  assign w_stage     = decode_stage(stage);
  assign w_stage_chg = (w_stage != r_prev_stage);
  assign w_is_fill   = (w_stage == ST_FILL) || (w_stage == ST_REFILL);
  assign w_agitate   = (w_stage == ST_WASH) || (w_stage == ST_RINSE);
  assign w_idle      = (w_stage == ST_IDLE);

  always_comb begin
    w_fill_cnt_nxt = '0;
    if (w_is_fill) begin
      if (w_stage_chg)                 w_fill_cnt_nxt = FC_W'(1);
      else if (r_fill_cnt != c_fill_to) w_fill_cnt_nxt = r_fill_cnt + 1'b1;
      else                             w_fill_cnt_nxt = r_fill_cnt;
    end
  end

  assign w_fill_to   = w_is_fill && !water_full && (w_fill_cnt_nxt == c_fill_to);
  assign w_door_flt  = !w_idle && !door_closed;
  assign w_fault_nxt = r_fault || w_fill_to || w_door_flt;

  // Transitions into a run state wait for motor_dir to already match, so the
  // direction line is only ever rewritten during motor-off cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph_cnt;
    if (w_fault_nxt || w_stage_chg) begin
      w_state_nxt = M_OFF;
      w_ph_nxt    = '0;
    end else begin
      case (r_state)
        M_OFF: begin
          if (w_agitate && !r_motor_dir) begin
            w_state_nxt = M_FWD;
            w_ph_nxt    = '0;
          end else if (w_stage == ST_SPIN) begin
            w_state_nxt = M_DWELL_F;
            w_ph_nxt    = '0;
          end
        end
        M_FWD, M_REV: begin
          if (r_ph_cnt != c_rev_last) begin
            w_ph_nxt = r_ph_cnt + 1'b1;
          end else begin
            w_state_nxt = (r_state == M_FWD) ? M_DWELL_F : M_DWELL_R;
            w_ph_nxt    = '0;
          end
        end
        M_DWELL_F: begin
          if (r_ph_cnt != c_dwell_last) begin
            w_ph_nxt = r_ph_cnt + 1'b1;
          end else if (w_agitate && r_motor_dir) begin
            w_state_nxt = M_REV;
            w_ph_nxt    = '0;
          end else if (!w_agitate && !r_motor_dir) begin
            w_state_nxt = M_SPIN;
            w_ph_nxt    = '0;
          end
        end
        M_DWELL_R: begin
          if (r_ph_cnt != c_dwell_last) begin
            w_ph_nxt = r_ph_cnt + 1'b1;
          end else if (!r_motor_dir) begin
            w_state_nxt = M_FWD;
            w_ph_nxt    = '0;
          end
        end
        M_SPIN:  w_state_nxt = M_SPIN;
        default: w_state_nxt = M_OFF;
      endcase
    end

    w_en_nxt  = (w_state_nxt == M_FWD) || (w_state_nxt == M_REV) || (w_state_nxt == M_SPIN);
    w_dir_nxt = r_motor_dir;
    if (!r_motor_en && !w_en_nxt)
      w_dir_nxt = (w_state_nxt == M_DWELL_F) && w_agitate;

    w_hold_nxt = '0;
    if ((r_prev_stage == ST_SPIN) && (w_stage != ST_SPIN)) w_hold_nxt = c_hold;
    else if (r_hold != '0)                                 w_hold_nxt = r_hold - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_stage <= ST_IDLE;
      r_state      <= M_OFF;
      r_ph_cnt     <= '0;
      r_fill_cnt   <= '0;
      r_hold       <= '0;
      r_inlet      <= 1'b0;
      r_drain      <= 1'b0;
      r_motor_en   <= 1'b0;
      r_motor_dir  <= 1'b0;
      r_fast       <= 1'b0;
      r_lock       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_prev_stage <= w_stage;
      r_state      <= w_state_nxt;
      r_ph_cnt     <= w_ph_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_inlet      <= w_is_fill && !water_full && !w_fault_nxt;
      r_drain      <= (((w_stage == ST_DRAIN) && !water_empty) || (w_stage == ST_SPIN)) && !w_fault_nxt;
      r_motor_en   <= w_en_nxt;
      r_motor_dir  <= w_dir_nxt;
      r_fast       <= (w_state_nxt == M_SPIN);
      r_lock       <= !w_idle || (w_hold_nxt != '0);
      r_fault      <= w_fault_nxt;
    end
  end

  awmc_beeper #(
    .BEEP_ON    (BEEP_ON),
    .BEEP_COUNT (BEEP_COUNT)
  ) u_beeper (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (done),
    .buzzer  (buzzer)
  );

  assign inlet_valve = r_inlet;
  assign drain_pump  = r_drain;
  assign motor_en    = r_motor_en;
  assign motor_dir   = r_motor_dir;
  assign motor_fast  = r_fast;
  assign door_lock   = r_lock;
  assign fault       = r_fault;

endmodule
`default_nettype wire
